// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and line levels for the 8N1 frame.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with head-of-queue read data taken straight from the storage
// flops, so a consumer can pop and capture the head in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push while full is refused regardless of a simultaneous pop.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    // NOTE: storage is deliberately not reset; empty slots are never read, and resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised onto txd
// with a per-frame baud divisor and synchronised CTS flow control.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_ovf,
    input  logic                   cts_n,
    output logic                   txd,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int                BIT_W    = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [DIV_W-1:0]          timer_q, timer_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      ovf_q, ovf_d;
    logic                      cts_meta_q, cts_sync_q;
    logic                      cts_ok, bit_end, start_frame, pop;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] head;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (wr_en),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    assign cts_ok   = !cts_sync_q;
    assign bit_end  = (timer_q == '0);
    assign txd      = txd_q;
    assign busy     = (state_q != IDLE);
    assign tx_done  = (state_q == STOP) && bit_end;
    assign overflow = ovf_q;

    // Two-flop synchroniser for the asynchronous CTS input; resets to "not clear".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    // Sticky overflow: a refused push sets it and wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full) ovf_d = 1'b1;
        else if (clr_ovf)  ovf_d = 1'b0;
    end

    // Frame sequencing: bit timing, shifting and the next txd level.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        timer_d     = timer_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        start_frame = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = UART_STOP_LVL;
                if (!fifo_empty && cts_ok) start_frame = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    timer_d = div_q;
                    txd_d   = shift_q[0];
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = div_q;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        txd_d   = UART_STOP_LVL;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty && cts_ok) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = UART_STOP_LVL;
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = UART_STOP_LVL;
            end
        endcase
        // Frame start: capture the head byte and the divisor for the whole frame.
        if (start_frame) begin
            state_d = START;
            shift_d = head;
            div_d   = baud_div;
            timer_d = baud_div;
            txd_d   = UART_START_LVL;
        end
    end

    assign pop = start_frame;

    // FSM and datapath registers; txd comes straight from a flop so the pad never glitches.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= UART_STOP_LVL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-and-frame model checked every cycle,
// plus directed scenarios with hand-computed waveforms and counts.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] baud_div;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic [4:0]       count;
    logic             overflow;
    logic             clr_ovf;
    logic             cts_n;
    logic             txd;
    logic             busy;
    logic             tx_done;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_div (baud_div),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .cts_n    (cts_n),
        .txd      (txd),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending bytes as a queue; an active frame as a 10-bit line pattern walked
    // at (div+1) clocks per symbol.
    byte unsigned mq[$];
    bit           m_ovf = 1'b0;
    bit           m_c1 = 1'b1, m_c2 = 1'b1;
    bit           m_act = 1'b0;
    logic [9:0]   m_bits = '1;
    int           m_div = 0;
    int           m_pos = 0;

    always @(posedge clk or posedge reset) begin
        int          flen;
        bit          fend, ok, start, push;
        byte unsigned d;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_c1  = 1'b1;
            m_c2  = 1'b1;
            m_act = 1'b0;
            m_pos = 0;
        end else begin
            flen  = 10 * (m_div + 1);
            fend  = m_act && (m_pos == flen - 1);
            ok    = !m_c2;
            start = (!m_act || fend) && (mq.size() != 0) && ok;
            push  = wr_en && (mq.size() < DEPTH);
            if (wr_en && mq.size() == DEPTH) m_ovf = 1'b1;
            else if (clr_ovf)                m_ovf = 1'b0;
            if (start) begin
                d      = mq.pop_front();
                m_bits = {1'b1, d, 1'b0};
                m_div  = int'(baud_div);
                m_pos  = 0;
                m_act  = 1'b1;
            end else if (fend) begin
                m_act = 1'b0;
            end else if (m_act) begin
                m_pos++;
            end
            if (push) mq.push_back(wr_data);
            m_c2 = m_c1;
            m_c1 = cts_n;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        logic e_txd;
        if (!reset) begin
            e_txd = m_act ? m_bits[m_pos / (m_div + 1)] : 1'b1;
            check("txd", 64'(txd), 64'(e_txd));
            check("busy", 64'(busy), 64'(m_act));
            check("tx_done", 64'(tx_done), 64'(m_act && (m_pos == 10 * (m_div + 1) - 1)));
            check("count", 64'(count), 64'(mq.size()));
            check("full", 64'(full), 64'(mq.size() == DEPTH));
            check("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int bound, output int cyc);
        cyc = 0;
        while (busy !== lvl && cyc < bound) begin
            tick(1);
            cyc++;
        end
    endtask

    initial begin
        logic [39:0] got40, exp40;
        logic [29:0] got30, exp30;
        logic [9:0]  got10, exp10;
        int          done_cnt, done_pos, cyc, lat, busy_seen, busy_len;

        reset    = 1'b1;
        baud_div = 16'd3;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        clr_ovf  = 1'b0;
        cts_n    = 1'b0;
        tick(3);
        check("rst_txd", 64'(txd), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_done", 64'(tx_done), 64'd0);
        reset = 1'b0;
        tick(3);

        // 1: single byte A5 at 4 clocks/bit.
        exp40 = 40'b0000_1111_0000_1111_0000_0000_1111_0000_1111_1111;
        push(8'hA5);
        done_cnt = 0;
        done_pos = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            got40[39-i] = txd;
            if (tx_done) begin
                done_cnt++;
                done_pos = i;
            end
        end
        check("t1_wave", 64'(got40), 64'(exp40));
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_done_pos", 64'(done_pos), 64'd39);
        tick(1);
        check("t1_busy_after", 64'(busy), 64'd0);

        // 2: three back-to-back bytes at 1 clock/bit, no idle gap.
        baud_div = 16'd0;
        tick(2);
        exp30 = 30'b0000000001_0111111111_0101010101;
        wr_en = 1'b1;
        wr_data = 8'h00;
        tick(1);
        wr_data = 8'hFF;
        tick(1);
        got30[29] = txd;
        wr_data = 8'h55;
        tick(1);
        wr_en = 1'b0;
        got30[28] = txd;
        check("t2_count_after_pushes", 64'(count), 64'd2);
        for (int i = 2; i < 30; i++) begin
            tick(1);
            got30[29-i] = txd;
        end
        check("t2_wave", 64'(got30), 64'(exp30));
        tick(1);
        check("t2_idle_after", 64'(busy), 64'd0);

        // 3: CTS held off, fill the FIFO, overflow behaviour.
        baud_div = 16'd3;
        cts_n = 1'b1;
        tick(4);
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        check("t3_full", 64'(full), 64'd1);
        check("t3_count", 64'(count), 64'd16);
        check("t3_txd_idle", 64'(txd), 64'd1);
        check("t3_ovf_pre", 64'(overflow), 64'd0);
        push(8'hEE);
        check("t3_ovf_set", 64'(overflow), 64'd1);
        check("t3_count_held", 64'(count), 64'd16);
        clr_ovf = 1'b1;
        push(8'hEF);
        check("t3_set_wins", 64'(overflow), 64'd1);
        tick(1);
        clr_ovf = 1'b0;
        check("t3_ovf_clr", 64'(overflow), 64'd0);

        // 4: release CTS, drop it mid-frame, frame completes, resume after sync.
        cts_n = 1'b0;
        wait_busy(1'b1, 20, cyc);
        check("t4_start_timeout", 64'(cyc < 20), 64'd1);
        tick(10);
        cts_n = 1'b1;
        wait_busy(1'b0, 100, cyc);
        check("t4_frame_end_timeout", 64'(cyc < 100), 64'd1);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) busy_seen++;
        end
        check("t4_held_off", 64'(busy_seen), 64'd0);
        cts_n = 1'b0;
        wait_busy(1'b1, 20, lat);
        check("t4_resume_lat_ok", 64'(lat >= 2 && lat <= 3), 64'd1);

        // 5: reset during data bit 4 of the running frame, then a clean frame.
        tick(21);
        check("t5_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_txd", 64'(txd), 64'd1);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_count", 64'(count), 64'd0);
        check("t5_rst_full", 64'(full), 64'd0);
        tick(2);
        reset = 1'b0;
        baud_div = 16'd0;
        tick(3);
        exp10 = 10'b0001111001;
        push(8'h3C);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            got10[9-i] = txd;
        end
        check("t5_wave", 64'(got10), 64'(exp10));
        tick(2);

        // 6: divisor change mid-frame applies to the next frame only (40 + 80 clocks).
        baud_div = 16'd3;
        tick(1);
        push(8'h81);
        push(8'h7E);
        busy_len = 0;
        while (busy && busy_len < 500) begin
            busy_len++;
            if (busy_len == 10) baud_div = 16'd7;
            tick(1);
        end
        check("t6_busy_len", 64'(busy_len), 64'd120);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop so the run always ends even if a wait loop misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
